// File: rtl/snn_inference_sequencer.sv
// Timestep sequencer for a two-layer spiking classifier: latches an image, clears the network,
// issues T_STEPS pulses, counts output spikes per class and reports the winning class.
module snn_inference_sequencer #(
    parameter int N_PIX      = 25,
    parameter int N_OUT      = 2,
    parameter int T_STEPS    = 16,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8,
    localparam int IDX_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N_PIX-1:0]       pix_in,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       class_idx,
    output logic [N_OUT*CNT_W-1:0] spike_count,
    output logic                   net_reset,
    output logic                   net_pulse,
    output logic [N_PIX-1:0]       net_pixel,
    input  logic [N_OUT-1:0]       net_spike
);
    localparam int STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STEP, SETTLE, DECIDE, DONE} state_t;

    state_t             state_reg, state_next;
    logic [STEP_W-1:0]  step_reg;
    logic [SET_W-1:0]   settle_reg;
    logic [IDX_W-1:0]   class_idx_reg;
    logic [N_PIX-1:0]   net_pixel_reg;
    logic               busy_reg, done_reg, net_reset_reg, net_pulse_reg;
    logic               busy_next, done_next, net_reset_next, net_pulse_next;
    logic               accept, abort_taken, last_settle, last_step, sample;
    logic [IDX_W-1:0]   best_idx;
    logic [CNT_W-1:0]   best_val;

    assign accept      = (state_reg == IDLE) && start;
    assign abort_taken = abort && (state_reg != IDLE);
    assign last_settle = (settle_reg == SET_W'(SETTLE_CYC - 1));
    assign last_step   = (step_reg == STEP_W'(T_STEPS - 1));
    assign sample      = (state_reg == SETTLE) && last_settle && !abort_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = STEP;
            STEP:    state_next = SETTLE;
            SETTLE:  if (last_settle) state_next = last_step ? DECIDE : STEP;
            DECIDE:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_taken) begin
            state_next = IDLE;
        end
    end

    // Control outputs are decoded from the next state and registered, so they align with the state.
    always_comb begin
        busy_next      = (state_next == CLEAR) || (state_next == STEP) ||
                         (state_next == SETTLE) || (state_next == DECIDE);
        done_next      = (state_next == DONE);
        net_pulse_next = (state_next == STEP);
        net_reset_next = (state_next == CLEAR) || abort_taken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            net_pulse_reg <= 1'b0;
            net_reset_reg <= 1'b1;
            net_pixel_reg <= '0;
            class_idx_reg <= '0;
            step_reg      <= '0;
            settle_reg    <= '0;
        end else begin
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            net_pulse_reg <= net_pulse_next;
            net_reset_reg <= net_reset_next;
            if (accept) begin
                net_pixel_reg <= pix_in;
                step_reg      <= '0;
            end else if (sample && !last_step) begin
                step_reg <= step_reg + STEP_W'(1);
            end
            if (state_reg == SETTLE && !last_settle) begin
                settle_reg <= settle_reg + SET_W'(1);
            end else begin
                settle_reg <= '0;
            end
            if (state_reg == DECIDE && !abort_taken) begin
                class_idx_reg <= best_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : gen_cnt
            logic [CNT_W-1:0] count_reg;
            always_ff @(posedge clk) begin
                if (reset || accept) begin
                    count_reg <= '0;
                end else if (sample && net_spike[gi] && (count_reg != {CNT_W{1'b1}})) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
            assign spike_count[gi*CNT_W +: CNT_W] = count_reg;
        end
    endgenerate

    // Strict greater-than keeps the lowest index on ties and yields 0 when all counts are zero.
    always_comb begin
        best_idx = '0;
        best_val = spike_count[0 +: CNT_W];
        for (int i = 1; i < N_OUT; i++) begin
            if (spike_count[i*CNT_W +: CNT_W] > best_val) begin
                best_val = spike_count[i*CNT_W +: CNT_W];
                best_idx = IDX_W'(i);
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign class_idx = class_idx_reg;
    assign net_reset = net_reset_reg;
    assign net_pulse = net_pulse_reg;
    assign net_pixel = net_pixel_reg;
endmodule
